// File: rtl/cyber_player_if.sv
// Signal bundle between the game controller and the emulated key player.
// The controller side drives pacing and difficulty; the player side returns key activity.
interface cyber_player_if;
  logic       enable;
  logic       tick;
  logic [8:0] speed;
  logic       pressed;
  logic       press_pulse;
  logic [7:0] presses;

  modport master (
    output enable, tick, speed,
    input  pressed, press_pulse, presses
  );

  modport slave (
    input  enable, tick, speed,
    output pressed, press_pulse, presses
  );
endinterface

// File: rtl/cyber_player.sv
// Emulated key player: an LFSR-driven decision issues timed press/release levels
// whose rising edges each represent exactly one button event.
module cyber_player #(
  parameter int unsigned HOLD_TICKS = 2,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic           Clock,
  input  logic           rst_n,
  cyber_player_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_TICKS - 1);
  localparam logic [9:0] LFSR_SEED = 10'h001;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] lfsr_q, lfsr_d;
  logic       pressed_q, pressed_d;
  logic       pulse_q, pulse_d;
  logic [7:0] presses_q, presses_d;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    pulse_d   = 1'b0;
    presses_d = presses_q;

    if (!bus.enable) begin
      // Pausing abandons any press in progress; a tick on this cycle is ignored.
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.tick) begin
      lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
      unique case (state_q)
        IDLE: begin
          // Decision uses the value the LFSR holds before this tick advances it.
          if ({1'b0, bus.speed} > lfsr_q) begin
            state_d = PRESS;
            cnt_d   = '0;
            pulse_d = 1'b1;
            if (presses_q != 8'hFF) presses_d = presses_q + 8'd1;
          end
        end
        PRESS: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    pressed_d = (state_d == PRESS);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      pressed_q <= 1'b0;
      pulse_q   <= 1'b0;
      presses_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      pressed_q <= pressed_d;
      pulse_q   <= pulse_d;
      presses_q <= presses_d;
    end
  end

  assign bus.pressed     = pressed_q;
  assign bus.press_pulse = pulse_q;
  assign bus.presses     = presses_q;

endmodule

// File: tb/tb_cyber_player.sv
// Self-checking bench for cyber_player: randomized pacing against a tick-level
// behavioural model, plus literal expectations for the documented scenarios.
module tb_cyber_player;

  localparam int H = 2;
  localparam int G = 1;
  localparam int PERIOD = 1023;

  logic Clock = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cyber_player_if bus ();

  cyber_player #(.HOLD_TICKS(H), .GAP_TICKS(G)) dut (
    .Clock (Clock),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sequence of LFSR values, index 0 is the seed.
  int seq [0:PERIOD];
  initial begin
    seq[0] = 1;
    for (int i = 0; i < PERIOD; i++)
      seq[i+1] = ((seq[i] << 1) & 'h3FE) | (((seq[i] >> 9) ^ (seq[i] >> 6)) & 1);
  end

  // Behavioural model: m_since counts enabled ticks since the current press began
  // (-1 = waiting for a decision). Key is held for the first H ticks, then released G.
  int m_since = -1;
  int m_idx = 0;
  int m_presses = 0;
  bit m_pulse = 0;
  int m_ticks = 0;
  int last_pulse_tick = -1000;

  always @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      m_since = -1; m_idx = 0; m_presses = 0; m_pulse = 0;
      m_ticks = 0; last_pulse_tick = -1000;
    end else begin
      m_pulse = 0;
      if (!bus.enable) begin
        m_since = -1;
        last_pulse_tick = -1000;
      end else if (bus.tick) begin
        m_ticks++;
        if (m_since < 0) begin
          if (int'(bus.speed) > seq[m_idx]) begin
            m_since = 0;
            m_pulse = 1;
            m_presses = (m_presses == 255) ? 255 : m_presses + 1;
          end
        end else begin
          m_since++;
          if (m_since == H + G) m_since = -1;
        end
        m_idx = (m_idx + 1) % PERIOD;
      end
    end
  end

  // Per-cycle comparison, plus a bench-side rising-edge detector on pressed.
  bit prev_pressed = 0;
  int det_cnt = 0;
  int pulse_cnt = 0;
  int phase_pulses = 0;

  always @(negedge Clock) begin
    if (rst_n) begin
      check("pressed", bus.pressed, (m_since >= 0 && m_since < H));
      check("press_pulse", bus.press_pulse, m_pulse);
      check("presses", bus.presses, m_presses);
      check("lfsr", dut.lfsr_q, seq[m_idx]);
      if (bus.press_pulse) begin
        check("pulse_spacing", (m_ticks - last_pulse_tick) >= H + G + 1, 1);
        last_pulse_tick = m_ticks;
        pulse_cnt++;
        phase_pulses++;
      end
    end
    if (bus.pressed && !prev_pressed) det_cnt++;
    prev_pressed = bus.pressed;
  end

  task automatic do_ticks(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      @(negedge Clock);
      bus.tick = 1'b0;
      repeat (period - 1) @(negedge Clock);
    end
  endtask

  task automatic apply_reset();
    bus.enable = 1'b0;
    bus.tick   = 1'b0;
    @(negedge Clock);
    rst_n = 1'b0;
    repeat (2) @(negedge Clock);
    rst_n = 1'b1;
  endtask

  task automatic wait_pressed(input string name);
    int n = 0;
    while (!bus.pressed && n < 400) begin
      do_ticks(1, 1);
      n++;
    end
    check(name, bus.pressed, 1);
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.tick   = 1'b0;
    bus.speed  = '0;

    // Model pins: known LFSR prefix and full period.
    check("seq_7", seq[7], 'h081);
    check("seq_period", seq[PERIOD], 'h001);

    // Reset state.
    repeat (2) @(negedge Clock);
    check("rst_pressed", bus.pressed, 0);
    check("rst_pulse", bus.press_pulse, 0);
    check("rst_presses", bus.presses, 0);
    check("rst_lfsr", dut.lfsr_q, 'h001);
    rst_n = 1'b1;

    // First decision presses at seed 001; held 2 ticks, released 1, then next decision.
    bus.enable = 1'b1;
    bus.speed  = 9'h1FF;
    do_ticks(1, 1);
    check("first_pressed", bus.pressed, 1);
    check("first_pulse", bus.press_pulse, 1);
    check("first_presses", bus.presses, 1);
    @(negedge Clock);
    check("pulse_one_cycle", bus.press_pulse, 0);
    do_ticks(1, 4);
    check("hold_tick1", bus.pressed, 1);
    do_ticks(1, 4);
    check("gap_tick2", bus.pressed, 0);
    do_ticks(1, 4);
    check("idle_tick3", bus.pressed, 0);
    do_ticks(1, 1);
    check("second_pulse", bus.press_pulse, 1);
    check("second_presses", bus.presses, 2);

    // speed=0 never presses; LFSR returns to seed after its full period.
    apply_reset();
    bus.enable = 1'b1;
    bus.speed  = '0;
    do_ticks(PERIOD, 1);
    check("lfsr_wrap", dut.lfsr_q, 'h001);
    do_ticks(2000 - PERIOD, 1);
    check("speed0_presses", bus.presses, 0);

    // Max speed over 4000 ticks: pulses counted, presses saturates at FF.
    apply_reset();
    phase_pulses = 0;
    bus.enable = 1'b1;
    bus.speed  = 9'h1FF;
    do_ticks(4000, 1);
    check("sat_count", bus.presses, (phase_pulses > 255) ? 255 : phase_pulses);
    check("sat_ff", bus.presses, 'hFF);

    // Drop enable mid-press, with a simultaneous tick that must be ignored.
    apply_reset();
    bus.enable = 1'b1;
    bus.speed  = 9'h1FF;
    wait_pressed("wait_press_en");
    bus.enable = 1'b0;
    bus.tick   = 1'b1;
    @(negedge Clock);
    check("en_drop_pressed", bus.pressed, 0);
    check("en_drop_pulse", bus.press_pulse, 0);
    for (int i = 0; i < 20; i++) begin
      bus.tick = 1'($urandom_range(0, 1));
      @(negedge Clock);
    end
    bus.tick   = 1'b0;
    bus.enable = 1'b1;
    do_ticks(40, 2);

    // Randomized pacing, pauses and difficulty changes.
    for (int i = 0; i < 3000; i++) begin
      bus.enable = ($urandom_range(0, 19) != 0);
      bus.tick   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.speed = '0;
          1:       bus.speed = 9'h1FF;
          default: bus.speed = 9'($urandom_range(0, 511));
        endcase
      end
      @(negedge Clock);
    end

    // Asynchronous reset between edges during a press.
    bus.enable = 1'b1;
    bus.speed  = 9'h1FF;
    wait_pressed("wait_press_rst");
    @(posedge Clock);
    #2 rst_n = 1'b0;
    #1;
    check("async_pressed", bus.pressed, 0);
    check("async_pulse", bus.press_pulse, 0);
    check("async_presses", bus.presses, 0);
    check("async_lfsr", dut.lfsr_q, 'h001);
    @(negedge Clock);
    rst_n = 1'b1;
    do_ticks(50, 1);

    @(negedge Clock);
    check("edge_detector", det_cnt, pulse_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cyber_player.md
CYBER_PLAYER -- requirements
Module: cyber_player

Interface
REQ-001 Parameter HOLD_TICKS, default 2: ticks the emulated key stays pressed (legal 1..15).
REQ-002 Parameter GAP_TICKS, default 1: ticks the emulated key stays released before a new decision (legal 1..15).
REQ-003 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 enable  input  1  game running; 0 freezes play (game over or paused).
REQ-006 tick  input  1  one-Clock strobe from the slow clock divider; all pacing counts ticks.
REQ-007 speed  input  9  difficulty threshold from switches; 0 = never press, larger = more frequent.
REQ-008 pressed  output  1  emulated key level, 1 = held; drives the player-side button edge detector.
REQ-009 press_pulse  output  1  one-Clock pulse marking each new press.
REQ-010 presses  output  8  saturating count of presses issued since reset.

Function
REQ-011 Block SHALL be the generating end of the key-input path: it produces press/release levels that a rising-edge detector turns into exactly one event per press.
REQ-012 Internal 10-bit LFSR SHALL use polynomial x^10+x^7+1 (next bit = lfsr[9] XOR lfsr[6], shifted into bit 0), seed 10'h001; never reaches 0.
REQ-013 LFSR SHALL advance exactly once per Clock where tick=1 and enable=1, in every state; otherwise hold.
REQ-014 State machine SHALL have three states: IDLE, PRESS, GAP.
REQ-015 IDLE: on tick=1 and enable=1, if {1'b0,speed} > current (pre-advance) LFSR value, go to PRESS; else stay IDLE.
REQ-016 PRESS: pressed=1; internal 4-bit tick counter counts ticks; after HOLD_TICKS ticks spent in PRESS, go to GAP.
REQ-017 GAP: pressed=0; after GAP_TICKS ticks spent in GAP, go to IDLE; guarantees a released interval between presses.
REQ-018 Tick counter SHALL clear on every state transition; ticks are counted only while enable=1.
REQ-019 pressed SHALL be registered: 1 exactly while state=PRESS, 0 otherwise.
REQ-020 press_pulse SHALL be 1 for exactly the one Clock cycle immediately after the IDLE->PRESS transition edge (i.e. first cycle pressed=1), 0 otherwise.
REQ-021 presses SHALL increment by 1 on each IDLE->PRESS transition, saturating at 8'hFF (no wrap).
REQ-022 enable=0 at any Clock edge SHALL force state IDLE, counter 0, pressed 0 on that edge; LFSR and presses hold; no press_pulse.
REQ-023 speed=0 SHALL never cause a press; speed=511 presses whenever LFSR<511 (just under half of LFSR states).
REQ-024 speed changes SHALL take effect at the next IDLE decision; a press in progress completes unchanged.
REQ-025 tick arriving on the same cycle enable falls SHALL be ignored (enable=0 dominates).
REQ-026 Maximum press rate: one press per HOLD_TICKS+GAP_TICKS+1 ticks.

Reset
REQ-027 Reset=0 SHALL immediately, without Clock, set state IDLE, tick counter 0, LFSR 10'h001, pressed 0, press_pulse 0, presses 0.
REQ-028 Reset asserted mid-PRESS SHALL drop pressed to 0 asynchronously; no partial count remains.
REQ-029 After Reset returns to 1, first decision SHALL occur at the first tick with enable=1.

Verification
REQ-030 Reset, enable=1, speed=9'h1FF, tick every 4 Clocks -> first tick: LFSR 001 < 511, PRESS entered; press_pulse one cycle; pressed high 2 ticks, low 1 tick; presses=1.
REQ-031 speed=0, enable=1, 2000 ticks -> pressed never 1, presses stays 0, LFSR visits 1023 states then returns to 10'h001.
REQ-032 speed=9'h1FF, 4000 ticks -> count of press_pulse equals presses (until saturation at 255, then presses holds FF); no two pulses closer than 4 ticks.
REQ-033 Drop enable during PRESS -> pressed 0 at next Clock edge, no further pulses, LFSR frozen; re-raise enable -> resumes from IDLE with held LFSR value.
REQ-034 Assert Reset asynchronously between Clock edges during PRESS -> pressed falls before next Clock; all outputs at reset values.
REQ-035 Feed pressed into the team's rising-edge button detector -> exactly one detector set pulse per press_pulse over 1000 ticks.
